// File: rtl/dna_port_pkg.sv
// Shared definitions for the device-DNA readout engine: width limits and controller states.
package dna_port_pkg;

   localparam int DNA_WIDTH_MIN     = 8;
   localparam int DNA_WIDTH_MAX     = 256;
   localparam int DNA_WIDTH_DEFAULT = 96;

   // Encodings kept identical to the legacy controller so state probes still decode.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_SHIFT = ST_SHIFT,
      S_HOLD  = ST_HOLD
   } dna_state_e;

   function automatic bit dna_width_legal(input int width);
      return (width >= DNA_WIDTH_MIN) && (width <= DNA_WIDTH_MAX);
   endfunction

endpackage

// File: rtl/dna_port_reader_if.sv
// Request/response bundle between a readout consumer and the DNA readout engine.
interface dna_port_reader_if
   import dna_port_pkg::*;
#(
   parameter int DNA_WIDTH = DNA_WIDTH_DEFAULT
);

   logic                 START;
   logic                 RELOAD;
   logic                 ABORT;
   logic                 BUSY;
   logic                 DNA_VALID;
   logic                 DNA_READY;
   logic [DNA_WIDTH-1:0] DNA_DATA;
   logic                 SER_BIT;

   modport master (
      output START,
      output RELOAD,
      output ABORT,
      output DNA_READY,
      input  BUSY,
      input  DNA_VALID,
      input  DNA_DATA,
      input  SER_BIT
   );

   modport slave (
      input  START,
      input  RELOAD,
      input  ABORT,
      input  DNA_READY,
      output BUSY,
      output DNA_VALID,
      output DNA_DATA,
      output SER_BIT
   );

endinterface

// File: rtl/dna_shift_chain.sv
// Behavioural model of the device DNA shift chain: READ loads the ID, SHIFT rotates it out LSB first.
module dna_shift_chain
   import dna_port_pkg::*;
#(
   parameter int                   DNA_WIDTH     = DNA_WIDTH_DEFAULT,
   parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = '0
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic READ,
   input  logic SHIFT,
   input  logic DIN,
   output logic DOUT
);

   logic [DNA_WIDTH-1:0] chain_q, chain_d;
   logic                 dout_q,  dout_d;

   always_comb begin
      chain_d = chain_q;
      dout_d  = dout_q;
      if (READ) begin
         chain_d = SIM_DNA_VALUE;
         dout_d  = SIM_DNA_VALUE[0];
      end else if (SHIFT) begin
         chain_d = {DIN, chain_q[DNA_WIDTH-1:1]};
         dout_d  = chain_q[1];
      end
   end

   // DOUT resets low even though the chain holds the ID; only READ or SHIFT refresh it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         chain_q <= SIM_DNA_VALUE;
         dout_q  <= 1'b0;
      end else begin
         chain_q <= chain_d;
         dout_q  <= dout_d;
      end
   end

   assign DOUT = dout_q;

endmodule

// File: rtl/dna_port_reader.sv
// Device-DNA readout engine: loads/shifts the DNA chain, reassembles the ID and offers it on valid/ready.
module dna_port_reader
   import dna_port_pkg::*;
#(
   parameter int                   DNA_WIDTH     = DNA_WIDTH_DEFAULT,
   parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = '0,
   parameter int                   LOOPBACK      = 1
) (
   input  logic               CLK,
   input  logic               RST_N,
   dna_port_reader_if.slave   dna_if
);

   if (!dna_width_legal(DNA_WIDTH)) begin : g_bad_width
      $fatal(1, "dna_port_reader: DNA_WIDTH %0d outside legal range %0d..%0d",
             DNA_WIDTH, DNA_WIDTH_MIN, DNA_WIDTH_MAX);
   end

   if ($bits(dna_if.DNA_DATA) != DNA_WIDTH) begin : g_bad_if_width
      $fatal(1, "dna_port_reader: interface DNA_DATA width %0d differs from DNA_WIDTH %0d",
             $bits(dna_if.DNA_DATA), DNA_WIDTH);
   end

   localparam int             CNT_W    = $clog2(DNA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_WIDTH - 1);

   dna_state_e           state_q,  state_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [DNA_WIDTH-1:0] shadow_q, shadow_d;
   logic [DNA_WIDTH-1:0] data_q,   data_d;
   logic                 valid_q,  valid_d;

   logic chain_read;
   logic chain_shift;
   logic chain_din;
   logic chain_dout;

   assign chain_din = (LOOPBACK != 0) ? chain_dout : 1'b0;

   dna_shift_chain #(
      .DNA_WIDTH     (DNA_WIDTH),
      .SIM_DNA_VALUE (SIM_DNA_VALUE)
   ) u_chain (
      .CLK   (CLK),
      .RST_N (RST_N),
      .READ  (chain_read),
      .SHIFT (chain_shift),
      .DIN   (chain_din),
      .DOUT  (chain_dout)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      data_d      = data_q;
      valid_d     = valid_q;
      chain_read  = 1'b0;
      chain_shift = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (dna_if.START && !dna_if.ABORT) begin
               cnt_d   = '0;
               state_d = dna_if.RELOAD ? S_LOAD : S_SHIFT;
            end
         end

         S_LOAD: begin
            if (dna_if.ABORT) begin
               state_d = S_IDLE;
            end else begin
               chain_read = 1'b1;
               cnt_d      = '0;
               state_d    = S_SHIFT;
            end
         end

         // DOUT already shows bit cnt; capturing and shifting on the same edge gives one bit per cycle.
         S_SHIFT: begin
            if (dna_if.ABORT) begin
               state_d = S_IDLE;
            end else begin
               shadow_d[cnt_q] = chain_dout;
               chain_shift     = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_HOLD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         // First HOLD cycle publishes the completed shadow; afterwards wait for the consumer.
         S_HOLD: begin
            if (!valid_q) begin
               data_d  = shadow_q;
               valid_d = 1'b1;
            end else if (dna_if.DNA_READY) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign dna_if.BUSY      = (state_q != S_IDLE);
   assign dna_if.DNA_VALID = valid_q;
   assign dna_if.DNA_DATA  = data_q;
   assign dna_if.SER_BIT   = chain_dout;

endmodule

// File: tb/tb_dna_port_reader.sv
// Directed bench for dna_port_reader: 96-bit loopback, 96-bit no-loopback and 8-bit instances.
module tb_dna_port_reader;

   localparam int          W    = 96;
   localparam logic [95:0] SIM  = 96'hA55A_1234_5678_9ABC_DEF0_3CC3;
   localparam logic [7:0]  SIM8 = 8'h81;

   logic CLK;
   logic rst_a, rst_b, rst_c;
   int   checks;
   int   errors;
   logic [95:0] sim_v;
   logic [95:0] rot;
   logic        flag;

   dna_port_reader_if #(.DNA_WIDTH(96)) ifa ();
   dna_port_reader_if #(.DNA_WIDTH(96)) ifb ();
   dna_port_reader_if #(.DNA_WIDTH(8))  ifc ();

   dna_port_reader #(.DNA_WIDTH(96), .SIM_DNA_VALUE(SIM), .LOOPBACK(1)) dut_a (
      .CLK (CLK), .RST_N (rst_a), .dna_if (ifa));
   dna_port_reader #(.DNA_WIDTH(96), .SIM_DNA_VALUE(SIM), .LOOPBACK(0)) dut_b (
      .CLK (CLK), .RST_N (rst_b), .dna_if (ifb));
   dna_port_reader #(.DNA_WIDTH(8), .SIM_DNA_VALUE(SIM8), .LOOPBACK(1)) dut_c (
      .CLK (CLK), .RST_N (rst_c), .dna_if (ifc));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      #2;
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifa.BUSY); end
      checks++; if (ifa.DNA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifa.DNA_VALID); end
      checks++; if (ifa.DNA_DATA !== 96'h0) begin errors++; $display("FAIL reset_data got %h exp 0", ifa.DNA_DATA); end
      checks++; if (ifa.SER_BIT !== 1'b0) begin errors++; $display("FAIL reset_ser got %b exp 0", ifa.SER_BIT); end
      checks++; if (ifc.DNA_DATA !== 8'h00) begin errors++; $display("FAIL reset_data_w8 got %h exp 00", ifc.DNA_DATA); end
      step(2);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      step(2);
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 0", ifa.BUSY); end
   endtask

   task automatic test_readout;
      ifa.DNA_READY = 1'b1; ifa.RELOAD = 1'b1; ifa.START = 1'b1;
      step(1);
      ifa.START = 1'b0;
      checks++; if (ifa.BUSY !== 1'b1) begin errors++; $display("FAIL busy_on_accept got %b exp 1", ifa.BUSY); end
      step(1);
      checks++; if (ifa.SER_BIT !== sim_v[0]) begin errors++; $display("FAIL ser_after_read got %b exp %b", ifa.SER_BIT, sim_v[0]); end
      step(2);
      checks++; if (ifa.SER_BIT !== sim_v[2]) begin errors++; $display("FAIL ser_after_2_shifts got %b exp %b", ifa.SER_BIT, sim_v[2]); end
      flag = 1'b0;
      for (int e = 4; e <= W + 1; e++) begin
         step(1);
         if (ifa.DNA_VALID !== 1'b0) flag = 1'b1;
      end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL valid_not_early got %b exp 0", flag); end
      step(1);
      checks++; if (ifa.DNA_VALID !== 1'b1) begin errors++; $display("FAIL valid_at_w_plus_2 got %b exp 1", ifa.DNA_VALID); end
      checks++; if (ifa.DNA_DATA !== SIM) begin errors++; $display("FAIL readout_data got %h exp %h", ifa.DNA_DATA, SIM); end
      step(1);
      checks++; if (ifa.DNA_VALID !== 1'b0) begin errors++; $display("FAIL valid_drop got %b exp 0", ifa.DNA_VALID); end
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL busy_drop got %b exp 0", ifa.BUSY); end
      checks++; if (ifa.DNA_DATA !== SIM) begin errors++; $display("FAIL data_retained got %h exp %h", ifa.DNA_DATA, SIM); end
   endtask

   task automatic test_hold_stall;
      ifa.DNA_READY = 1'b0; ifa.RELOAD = 1'b1; ifa.START = 1'b1;
      step(1);
      ifa.START = 1'b0;
      step(W + 2);
      checks++; if (ifa.DNA_VALID !== 1'b1) begin errors++; $display("FAIL stall_valid_rise got %b exp 1", ifa.DNA_VALID); end
      flag = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (ifa.DNA_VALID !== 1'b1 || ifa.DNA_DATA !== SIM || ifa.BUSY !== 1'b1) flag = 1'b0;
      end
      checks++; if (flag !== 1'b1) begin errors++; $display("FAIL stall_stable got %b exp 1", flag); end
      ifa.DNA_READY = 1'b1;
      step(1);
      checks++; if (ifa.DNA_VALID !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b exp 0", ifa.DNA_VALID); end
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL stall_release_busy got %b exp 0", ifa.BUSY); end
   endtask

   task automatic test_loopback;
      ifa.RELOAD = 1'b0; ifa.START = 1'b1;
      step(1);
      ifa.START = 1'b0;
      step(W);
      checks++; if (ifa.DNA_VALID !== 1'b0) begin errors++; $display("FAIL noreload_valid_early got %b exp 0", ifa.DNA_VALID); end
      step(1);
      checks++; if (ifa.DNA_VALID !== 1'b1) begin errors++; $display("FAIL noreload_valid_w_plus_1 got %b exp 1", ifa.DNA_VALID); end
      checks++; if (ifa.DNA_DATA !== SIM) begin errors++; $display("FAIL loopback_data got %h exp %h", ifa.DNA_DATA, SIM); end
      step(1);
   endtask

   task automatic test_loopback_off;
      ifb.DNA_READY = 1'b1; ifb.RELOAD = 1'b1; ifb.START = 1'b1;
      step(1);
      ifb.START = 1'b0;
      step(W + 2);
      checks++; if (ifb.DNA_DATA !== SIM) begin errors++; $display("FAIL nolb_first_data got %h exp %h", ifb.DNA_DATA, SIM); end
      step(1);
      ifb.RELOAD = 1'b0; ifb.START = 1'b1;
      step(1);
      ifb.START = 1'b0;
      step(W + 1);
      checks++; if (ifb.DNA_VALID !== 1'b1) begin errors++; $display("FAIL nolb_second_valid got %b exp 1", ifb.DNA_VALID); end
      checks++; if (ifb.DNA_DATA !== 96'h0) begin errors++; $display("FAIL nolb_second_data got %h exp 0", ifb.DNA_DATA); end
      step(1);
   endtask

   task automatic test_abort;
      ifa.DNA_READY = 1'b1; ifa.RELOAD = 1'b1; ifa.START = 1'b1;
      step(1);
      ifa.START = 1'b0;
      step(1 + 40);
      checks++; if (ifa.SER_BIT !== sim_v[40]) begin errors++; $display("FAIL ser_after_40 got %b exp %b", ifa.SER_BIT, sim_v[40]); end
      ifa.ABORT = 1'b1;
      step(1);
      ifa.ABORT = 1'b0;
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL abort_to_idle got %b exp 0", ifa.BUSY); end
      step(3);
      checks++; if (ifa.DNA_VALID !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b exp 0", ifa.DNA_VALID); end
      checks++; if (ifa.DNA_DATA !== SIM) begin errors++; $display("FAIL abort_data_kept got %h exp %h", ifa.DNA_DATA, SIM); end
      ifa.START = 1'b1; ifa.ABORT = 1'b1;
      step(1);
      ifa.START = 1'b0; ifa.ABORT = 1'b0;
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %b exp 0", ifa.BUSY); end
      // Chain is now rotated by 40: a no-reload readout returns the rotated ID.
      for (int k = 0; k < W; k++) rot[k] = sim_v[(k + 40) % W];
      ifa.RELOAD = 1'b0; ifa.START = 1'b1;
      step(1);
      ifa.START = 1'b0;
      step(20);
      ifa.START = 1'b1;
      step(1);
      ifa.START = 1'b0;
      step(W + 1 - 21);
      checks++; if (ifa.DNA_VALID !== 1'b1) begin errors++; $display("FAIL rotated_valid got %b exp 1", ifa.DNA_VALID); end
      checks++; if (ifa.DNA_DATA !== rot) begin errors++; $display("FAIL rotated_data got %h exp %h", ifa.DNA_DATA, rot); end
      step(1);
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL rotated_done_busy got %b exp 0", ifa.BUSY); end
      step(1);
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL start_not_queued got %b exp 0", ifa.BUSY); end
   endtask

   task automatic test_reset_mid;
      ifa.RELOAD = 1'b1; ifa.START = 1'b1;
      step(1);
      ifa.START = 1'b0;
      step(1 + 50);
      rst_a = 1'b0;
      #1;
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", ifa.BUSY); end
      checks++; if (ifa.DNA_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", ifa.DNA_VALID); end
      checks++; if (ifa.DNA_DATA !== 96'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", ifa.DNA_DATA); end
      checks++; if (ifa.SER_BIT !== 1'b0) begin errors++; $display("FAIL midrst_ser got %b exp 0", ifa.SER_BIT); end
      step(1);
      rst_a = 1'b1;
      step(2);
      checks++; if (ifa.BUSY !== 1'b0) begin errors++; $display("FAIL midrst_release_busy got %b exp 0", ifa.BUSY); end
   endtask

   task automatic test_w8;
      ifc.DNA_READY = 1'b1; ifc.RELOAD = 1'b1; ifc.START = 1'b1;
      step(1);
      ifc.START = 1'b0;
      step(9);
      checks++; if (ifc.DNA_VALID !== 1'b0) begin errors++; $display("FAIL w8_valid_early got %b exp 0", ifc.DNA_VALID); end
      step(1);
      checks++; if (ifc.DNA_VALID !== 1'b1) begin errors++; $display("FAIL w8_valid got %b exp 1", ifc.DNA_VALID); end
      checks++; if (ifc.DNA_DATA !== SIM8) begin errors++; $display("FAIL w8_data got %h exp %h", ifc.DNA_DATA, SIM8); end
      step(1);
      checks++; if (ifc.DNA_VALID !== 1'b0) begin errors++; $display("FAIL w8_valid_drop got %b exp 0", ifc.DNA_VALID); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sim_v  = SIM;
      rot    = '0;
      flag   = 1'b0;
      ifa.START = 1'b0; ifa.RELOAD = 1'b0; ifa.ABORT = 1'b0; ifa.DNA_READY = 1'b0;
      ifb.START = 1'b0; ifb.RELOAD = 1'b0; ifb.ABORT = 1'b0; ifb.DNA_READY = 1'b0;
      ifc.START = 1'b0; ifc.RELOAD = 1'b0; ifc.ABORT = 1'b0; ifc.DNA_READY = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      #1;
      test_reset();
      test_readout();
      test_hold_stall();
      test_loopback();
      test_loopback_off();
      test_abort();
      test_reset_mid();
      test_w8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
